weight_buf_writer: RTL and testbench

- Write-side counterpart of the weight-patch read address generator.
- Accepts a valid/ready stream of weight words from the loader/DMA and writes them into a ping-pong (2-bank) weight SRAM.
- Each bank holds NUM_FILTERS x K_R x K_S words, filter-major and tap-minor, which is the same order the read side walks.
- Hands each full bank to the reader with a full/release handshake, so loading of the next filter set overlaps compute.

---
 rtl/weight_buf_writer_pkg.sv | 29 ++
 rtl/wbw_tap_filt_cnt.sv | 43 ++++
 rtl/weight_buf_writer.sv | 129 ++++++++++++
 tb/tb_weight_buf_writer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buf_writer_pkg.sv
// Shared constants, types and address helper for the ping-pong weight buffer writer.
package weight_buf_writer_pkg;

    localparam int DATA_W      = 8;
    localparam int K_R         = 3;
    localparam int K_S         = 3;
    localparam int NUM_FILTERS = 2;
    localparam int KK          = K_R * K_S;
    localparam int DEPTH       = NUM_FILTERS * KK;
    localparam int AW          = $clog2(DEPTH);
    localparam int TAP_W       = (KK > 1) ? $clog2(KK) : 1;
    localparam int FILT_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int CHK_W       = DATA_W + AW;

    typedef logic [DATA_W-1:0] weight_t;
    typedef logic [AW-1:0]     wbuf_addr_t;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } wbw_state_e;

    // Filter-major, tap-minor: matches the order the read side walks a bank.
    function automatic wbuf_addr_t calc_addr(input logic [FILT_W-1:0] filt,
                                             input logic [TAP_W-1:0]  tap);
        return wbuf_addr_t'(filt) * wbuf_addr_t'(KK) + wbuf_addr_t'(tap);
    endfunction

endpackage

// File: rtl/wbw_tap_filt_cnt.sv
// Nested tap/filter counter producing the in-bank write address.
module wbw_tap_filt_cnt
    import weight_buf_writer_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_async_i,
    input  logic          en_i,
    output logic          last_tap_o,
    output logic          last_filt_o,
    output logic [AW-1:0] addr_o
);

    logic [TAP_W-1:0]  tap_q,  tap_d;
    logic [FILT_W-1:0] filt_q, filt_d;

    assign last_tap_o  = (tap_q  == TAP_W'(KK - 1));
    assign last_filt_o = (filt_q == FILT_W'(NUM_FILTERS - 1));
    assign addr_o      = calc_addr(filt_q, tap_q);

    always_comb begin
        tap_d  = tap_q;
        filt_d = filt_q;
        if (en_i) begin
            if (last_tap_o) begin
                tap_d  = '0;
                filt_d = last_filt_o ? '0 : filt_q + FILT_W'(1);
            end else begin
                tap_d  = tap_q + TAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            tap_q  <= '0;
            filt_q <= '0;
        end else begin
            tap_q  <= tap_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/weight_buf_writer.sv
// Streams weight words into a 2-bank SRAM and hands full banks to the reader.
// Optional running checksum per bank: define WEIGHT_BUF_WRITER_CHECKSUM_EN.
module weight_buf_writer
    import weight_buf_writer_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_async_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              wr_en_o,
    output logic              wr_bank_o,
    output logic [AW-1:0]     wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [1:0]        bank_full_o,
    input  logic              rd_release_i,
    input  logic              rd_bank_i,
`ifdef WEIGHT_BUF_WRITER_CHECKSUM_EN
    output logic [CHK_W-1:0]  chksum_o,
    output logic              chksum_vld_o,
`endif
    output logic              err_o
);

    wbw_state_e state_q;
    logic       cur_bank_q;
    logic       ready_en_q;
    logic [1:0] full_q, full_d;
    logic       err_q, err_d;
    logic       wr_en_q, wr_bank_q;
    wbuf_addr_t wr_addr_q;
    weight_t    wr_data_q;
    logic       accept;
    logic       last_tap, last_filt;
    wbuf_addr_t cnt_addr;

    // ready_en_q keeps s_ready_o low while reset is held, yet stays a pure register.
    assign s_ready_o = ready_en_q && (state_q == FILL) && !full_q[cur_bank_q];
    assign accept    = s_valid_i && s_ready_o;

    wbw_tap_filt_cnt u_cnt (
        .clk_i       (clk_i),
        .rst_async_i (rst_async_i),
        .en_i        (accept),
        .last_tap_o  (last_tap),
        .last_filt_o (last_filt),
        .addr_o      (cnt_addr)
    );

    // Releasing an empty bank is an error; the commit set is applied last so it wins.
    always_comb begin
        full_d = full_q;
        err_d  = err_q;
        if (rd_release_i) begin
            if (!full_q[rd_bank_i]) err_d = 1'b1;
            else                    full_d[rd_bank_i] = 1'b0;
        end
        if (state_q == COMMIT) full_d[cur_bank_q] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            state_q    <= FILL;
            cur_bank_q <= 1'b0;
            ready_en_q <= 1'b0;
            full_q     <= 2'b00;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            full_q     <= full_d;
            err_q      <= err_d;
            wr_en_q    <= accept;
            if (accept) begin
                wr_bank_q <= cur_bank_q;
                wr_addr_q <= cnt_addr;
                wr_data_q <= s_data_i;
            end
            case (state_q)
                FILL: begin
                    if (accept && last_tap && last_filt) state_q <= COMMIT;
                end
                COMMIT: begin
                    cur_bank_q <= ~cur_bank_q;
                    state_q    <= FILL;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_bank_o   = wr_bank_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign bank_full_o = full_q;
    assign err_o       = err_q;

`ifdef WEIGHT_BUF_WRITER_CHECKSUM_EN
    logic [CHK_W-1:0] acc_q;
    logic [CHK_W-1:0] chksum_q;
    logic             chksum_vld_q;

    // No beat is accepted during COMMIT, so acc_q is final when latched.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            acc_q        <= '0;
            chksum_q     <= '0;
            chksum_vld_q <= 1'b0;
        end else begin
            chksum_vld_q <= 1'b0;
            if (state_q == COMMIT) begin
                chksum_q     <= acc_q;
                chksum_vld_q <= 1'b1;
                acc_q        <= '0;
            end else if (accept) begin
                acc_q <= acc_q + CHK_W'(s_data_i);
            end
        end
    end

    assign chksum_o     = chksum_q;
    assign chksum_vld_o = chksum_vld_q;
`endif

endmodule

// File: tb/tb_weight_buf_writer.sv
// Directed bench for weight_buf_writer: fill, stall, release, error, async reset, random gaps.
module tb_weight_buf_writer;
    import weight_buf_writer_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_async_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [DATA_W-1:0] s_data_i;
    logic              wr_en_o;
    logic              wr_bank_o;
    logic [AW-1:0]     wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic [1:0]        bank_full_o;
    logic              rd_release_i;
    logic              rd_bank_i;
    logic              err_o;
`ifdef WEIGHT_BUF_WRITER_CHECKSUM_EN
    logic [CHK_W-1:0]  chksum_o;
    logic              chksum_vld_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    weight_buf_writer dut (
        .clk_i        (clk_i),
        .rst_async_i  (rst_async_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .wr_en_o      (wr_en_o),
        .wr_bank_o    (wr_bank_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .bank_full_o  (bank_full_o),
        .rd_release_i (rd_release_i),
        .rd_bank_i    (rd_bank_i),
`ifdef WEIGHT_BUF_WRITER_CHECKSUM_EN
        .chksum_o     (chksum_o),
        .chksum_vld_o (chksum_vld_o),
`endif
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // 18 back-to-back beats into the given bank, then the one-cycle commit bubble.
    task automatic fill_bank(input int bank, input int base);
        for (int j = 0; j < DEPTH; j++) begin
            s_valid_i = 1'b1;
            s_data_i  = DATA_W'(base + j);
            tick();
            chk("fill_wr_en",   32'(wr_en_o),   32'd1);
            chk("fill_wr_bank", 32'(wr_bank_o), 32'(bank));
            chk("fill_wr_addr", 32'(wr_addr_o), 32'(j));
            chk("fill_wr_data", 32'(wr_data_o), 32'((base + j) & 8'hFF));
        end
        s_valid_i = 1'b0;
        chk("commit_ready_low", 32'(s_ready_o), 32'd0);
        chk("commit_full_not_yet", 32'(bank_full_o[bank]), 32'd0);
        tick();
        chk("commit_no_write", 32'(wr_en_o), 32'd0);
        chk("commit_full_set", 32'(bank_full_o[bank]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, wr_seen;
        int cnt [2];
        bit armed [2];
        bit acc;

        rst_async_i  = 1'b1;
        s_valid_i    = 1'b0;
        s_data_i     = '0;
        rd_release_i = 1'b0;
        rd_bank_i    = 1'b0;
        #2;
        chk("rst_ready", 32'(s_ready_o),   32'd0);
        chk("rst_wr_en", 32'(wr_en_o),     32'd0);
        chk("rst_full",  32'(bank_full_o), 32'd0);
        chk("rst_err",   32'(err_o),       32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_async_i = 1'b0;
        tick();
        chk("ready_after_rst", 32'(s_ready_o), 32'd1);

        // Bank 0 with data 1..18
        fill_bank(0, 1);
        chk("b0_full", 32'(bank_full_o), 32'b01);
        chk("b0_ready_back", 32'(s_ready_o), 32'd1);
`ifdef WEIGHT_BUF_WRITER_CHECKSUM_EN
        chk("chksum_vld", 32'(chksum_vld_o), 32'd1);
        chk("chksum_val", 32'(chksum_o), 32'd171);
`endif

        // Bank 1 without any release, then a 20-cycle stall
        fill_bank(1, 101);
        chk("both_full", 32'(bank_full_o), 32'b11);
        s_valid_i = 1'b1;
        s_data_i  = 8'hEE;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_ready", 32'(s_ready_o), 32'd0);
            chk("stall_wr_en", 32'(wr_en_o),   32'd0);
        end

        // Release bank 0 while upstream keeps offering a word
        s_data_i     = 8'd55;
        rd_release_i = 1'b1;
        rd_bank_i    = 1'b0;
        tick();
        rd_release_i = 1'b0;
        chk("rel0_full",  32'(bank_full_o), 32'b10);
        chk("rel0_ready", 32'(s_ready_o),   32'd1);
        chk("rel0_no_wr", 32'(wr_en_o),     32'd0);
        tick();
        s_valid_i = 1'b0;
        chk("rel0_wr_en", 32'(wr_en_o),   32'd1);
        chk("rel0_bank",  32'(wr_bank_o), 32'd0);
        chk("rel0_addr",  32'(wr_addr_o), 32'd0);
        chk("rel0_data",  32'(wr_data_o), 32'd55);

        // Release of an empty bank is flagged and sticky
        rd_release_i = 1'b1;
        rd_bank_i    = 1'b0;
        tick();
        rd_release_i = 1'b0;
        chk("err_set",       32'(err_o),       32'd1);
        chk("err_flags_same", 32'(bank_full_o), 32'b10);
        tick();
        tick();
        chk("err_sticky", 32'(err_o), 32'd1);
        rd_release_i = 1'b1;
        rd_bank_i    = 1'b1;
        tick();
        rd_release_i = 1'b0;
        chk("rel1_full", 32'(bank_full_o), 32'b00);
        chk("rel1_err",  32'(err_o),       32'd1);

        // Six more beats (seven in bank 0), then async reset mid-cycle
        for (int j = 0; j < 6; j++) begin
            s_valid_i = 1'b1;
            s_data_i  = DATA_W'(60 + j);
            tick();
            chk("pre_rst_addr", 32'(wr_addr_o), 32'(j + 1));
        end
        s_valid_i = 1'b0;
        #3;
        rst_async_i = 1'b1;
        #1;
        chk("arst_ready", 32'(s_ready_o),   32'd0);
        chk("arst_wr_en", 32'(wr_en_o),     32'd0);
        chk("arst_bank",  32'(wr_bank_o),   32'd0);
        chk("arst_addr",  32'(wr_addr_o),   32'd0);
        chk("arst_data",  32'(wr_data_o),   32'd0);
        chk("arst_full",  32'(bank_full_o), 32'd0);
        chk("arst_err",   32'(err_o),       32'd0);
        #2;
        rst_async_i = 1'b0;
        tick();
        chk("arst_ready_back", 32'(s_ready_o), 32'd1);
        s_valid_i = 1'b1;
        s_data_i  = 8'd77;
        tick();
        s_valid_i = 1'b0;
        chk("arst_wr_en1", 32'(wr_en_o),     32'd1);
        chk("arst_bank1",  32'(wr_bank_o),   32'd0);
        chk("arst_addr1",  32'(wr_addr_o),   32'd0);
        chk("arst_data1",  32'(wr_data_o),   32'd77);
        chk("arst_full1",  32'(bank_full_o), 32'd0);

        // Clean restart, then three banks with random gaps and a delayed reader
        rst_async_i = 1'b1;
        tick();
        rst_async_i = 1'b0;
        tick();
        chk("rnd_start_ready", 32'(s_ready_o), 32'd1);
        sent    = 0;
        wr_seen = 0;
        cnt     = '{0, 0};
        armed   = '{0, 0};
        for (int cyc = 0; cyc < 3000 && wr_seen < 3 * DEPTH; cyc++) begin
            if (!s_valid_i && sent < 3 * DEPTH) s_valid_i = ($urandom_range(0, 1) == 1);
            s_data_i = DATA_W'(sent * 7 + 3);
            acc = s_valid_i && s_ready_o;
            for (int b = 0; b < 2; b++) begin
                if (bank_full_o[b] && !armed[b]) begin
                    armed[b] = 1'b1;
                    cnt[b]   = 10;
                end else if (armed[b] && cnt[b] > 0) begin
                    cnt[b]--;
                end
            end
            rd_release_i = 1'b0;
            for (int b = 0; b < 2; b++) begin
                if (armed[b] && cnt[b] == 0 && !rd_release_i) begin
                    rd_release_i = 1'b1;
                    rd_bank_i    = b[0];
                    armed[b]     = 1'b0;
                end
            end
            tick();
            if (acc) begin
                sent++;
                s_valid_i = 1'b0;
            end
            if (wr_en_o) begin
                chk("rnd_bank", 32'(wr_bank_o), 32'((wr_seen / DEPTH) % 2));
                chk("rnd_addr", 32'(wr_addr_o), 32'(wr_seen % DEPTH));
                chk("rnd_data", 32'(wr_data_o), 32'((wr_seen * 7 + 3) & 8'hFF));
                chk("rnd_not_full", 32'(bank_full_o[wr_bank_o]), 32'd0);
                wr_seen++;
            end
        end
        rd_release_i = 1'b0;
        s_valid_i    = 1'b0;
        chk("rnd_write_count", 32'(wr_seen), 32'(3 * DEPTH));
        chk("rnd_err", 32'(err_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
